bcd_seg7_scan: RTL and testbench
================================

// Module: bcd_seg7_scan
// PURPOSE
//  Downstream display stage for the 0-20 BCD counter. Takes the units/tens BCD digits
//  (Q0/Q1) and the overflow carry, and drives a multiplexed 2-digit common-anode
//  7-segment display. Captures one digit pair per refresh frame so the pair shown is
//  always consistent. Has a ghost-guard blank between digits, optional leading-zero
//  blanking, a dash for invalid BCD, and a sticky overflow dot.
// PARAMETERS
//  DIV_W      16     prescaler width
//  DIV        50000  CLK cycles each digit is lit; 2 <= DIV < 2**DIV_W
//  BLANK_CYC  4      ghost-guard cycles, all anodes off, after each digit; >= 1
//  SEG_AL     1      1: SEG/DP active-low, 0: active-high
//  AN_AL      1      1: AN active-low, 0: active-high
// PORTS
//  CLK     in   1  system clock, rising edge
//  CLR     in   1  asynchronous active-low reset
//  Q0      in   4  units BCD digit from the counter
//  Q1      in   4  tens BCD digit from the counter
//  OVF     in   1  overflow carry (counter RCO); sampled every cycle
//  DP_CLR  in   1  synchronous clear of the sticky overflow dot
//  LZB     in   1  1: blank the tens digit when it is 0
//  FREEZE  in   1  1: hold the current snapshot (no recapture)
//  SEG     out  7  segments {g,f,e,d,c,b,a}
//  DP      out  1  decimal point
//  AN      out  2  anode enables; AN[0]=units, AN[1]=tens
//  FRAME   out  1  1-cycle pulse, registered with the first lit cycle of each snapshot
// BEHAVIOUR
//  - One clock. CLR low forces all state to reset at once, with no clock needed.
//  - Reset values:
//      state S_G1, phase counter 0, snapshot 0, dot flag 0;
//      SEG/DP/AN all inactive, FRAME 0.
//  - Scan FSM cycles S_D0 -> S_G0 -> S_D1 -> S_G1 -> S_D0.
//      S_Dx lasts DIV cycles; S_Gx lasts BLANK_CYC cycles.
//      The phase counter counts 0..len-1, then clears and the state advances.
//      Frame period = 2*(DIV+BLANK_CYC) cycles.
//  - Snapshot: on the G1->D0 transition edge, {Q1,Q0} load into the shadow register
//    unless FREEZE=1. FRAME pulses on that same edge, even when FREEZE=1.
//    Input changes at any other time are not visible until the next frame.
//  - All outputs are registered. Pins reflect the current state one cycle after it is
//    entered. First FRAME after reset: at cycle BLANK_CYC+1.
//  - Decode, active-high gfedcba:
//      0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F
//      10..15: 40 (dash, g only)
//    With SEG_AL=1, SEG is the bitwise inverse.
//  - S_D0: AN drives units, SEG=dec(units), DP=dot flag.
//  - S_D1: AN drives tens, SEG=dec(tens), DP off.
//      If LZB=1 and tens==0, AN stays inactive and SEG is off for the whole phase.
//  - S_G0/S_G1: AN, SEG and DP all inactive.
//  - Dot flag:
//      set when OVF=1; cleared when DP_CLR=1;
//      if both in the same cycle, set wins; only CLR clears it asynchronously.
//  - Never more than one anode active in any cycle.
//  - Parameter limits are checked at elaboration; an illegal value is a fatal error.
// STRUCTURE
//  - Shared package bcd_disp_pkg holds:
//      typedef scan_state_t {S_D0,S_G0,S_D1,S_G1};
//      localparam 7-bit SEG_LUT[0:9], SEG_DASH=7'h40, SEG_OFF=7'h00.
//  - One sub-module: seg7_decode (4-bit BCD -> 7-bit active-high pattern, purely
//    combinational), instantiated once on the muxed digit.
//  - Top level holds the prescaler, FSM, snapshot, dot flag and output polarity
//    registers.
// TESTING (DIV=4, BLANK_CYC=2, SEG_AL=1, AN_AL=1; frame = 12 cycles)
//  1. Reset release:
//     -> SEG=7F, AN=11, DP=1 until FRAME at cycle 3; then AN=10 for 4 cycles,
//        AN=11 for 2, AN=01 for 4.
//  2. Q1=1, Q0=7:
//     -> units phase SEG=78, AN=10; tens phase SEG=79, AN=01.
//  3. LZB=1, Q1=0, Q0=5:
//     -> units SEG=12, AN=10; tens phase AN=11, SEG=7F.
//     LZB=0 -> tens SEG=40, AN=01.
//  4. Q0 changes 3->8 during S_D1:
//     -> remainder of the frame still shows 3; SEG=00 only after the next FRAME.
//     With FREEZE=1 the display holds 3 indefinitely.
//  5. Q0=4'hC:
//     -> units SEG=3F (dash).
//  6. OVF and DP_CLR pulsed in the same cycle:
//     -> DP=0 (lit) in every units phase.
//     DP_CLR alone -> DP=1 from the next units phase.
//     Async CLR pulse mid-S_D0 -> AN=11 immediately.

Source files
------------

// File: rtl/bcd_disp_pkg.sv
// Shared definitions for the BCD 7-segment display path: scan states and
// active-high gfedcba segment patterns.
package bcd_disp_pkg;

  typedef enum logic [1:0] {
    S_D0 = 2'd0,
    S_G0 = 2'd1,
    S_D1 = 2'd2,
    S_G1 = 2'd3
  } scan_state_t;

  localparam logic [6:0] SEG_LUT [0:9] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
    7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
  };
  localparam logic [6:0] SEG_DASH = 7'h40;
  localparam logic [6:0] SEG_OFF  = 7'h00;

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD to active-high gfedcba decoder; codes 10..15 show a dash.
module seg7_decode
  import bcd_disp_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    if (bcd <= 4'd9) seg = SEG_LUT[bcd];
  end

endmodule

// File: rtl/bcd_seg7_scan.sv
// Two-digit multiplexed common-anode display driver. A digit pair is captured
// once per frame so both digits shown in a frame always belong together.
module bcd_seg7_scan
  import bcd_disp_pkg::*;
#(
  parameter int DIV_W     = 16,
  parameter int DIV       = 50000,
  parameter int BLANK_CYC = 4,
  parameter int SEG_AL    = 1,
  parameter int AN_AL     = 1
) (
  input  logic       CLK,
  input  logic       CLR,
  input  logic [3:0] Q0,
  input  logic [3:0] Q1,
  input  logic       OVF,
  input  logic       DP_CLR,
  input  logic       LZB,
  input  logic       FREEZE,
  output logic [6:0] SEG,
  output logic       DP,
  output logic [1:0] AN,
  output logic       FRAME
);

  if (DIV_W < 1 || DIV_W > 31) begin : g_bad_div_w
    $fatal(1, "bcd_seg7_scan: DIV_W out of range");
  end
  if (DIV < 2 || DIV >= 2**DIV_W) begin : g_bad_div
    $fatal(1, "bcd_seg7_scan: DIV out of range");
  end
  if (BLANK_CYC < 1 || BLANK_CYC >= 2**DIV_W) begin : g_bad_blank
    $fatal(1, "bcd_seg7_scan: BLANK_CYC out of range");
  end

  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(DIV - 1);
  localparam logic [DIV_W-1:0] BLANK_LAST = DIV_W'(BLANK_CYC - 1);
  localparam logic [6:0]       SEG_INV    = (SEG_AL != 0) ? 7'h7F : 7'h00;
  localparam logic             DP_INV     = (SEG_AL != 0);
  localparam logic [1:0]       AN_INV     = (AN_AL != 0) ? 2'b11 : 2'b00;

  scan_state_t      state, state_nxt;
  logic [DIV_W-1:0] cnt, cnt_nxt;
  logic             phase_end;
  logic [3:0]       snap_u, snap_t;
  logic             dot;
  logic [3:0]       digit;
  logic [6:0]       dec_seg;
  logic [6:0]       seg_on;
  logic [1:0]       an_on;
  logic             dp_on;
  logic             frame_nxt;

  // Phase sequencing: the counter runs 0..len-1 in each state, then the state advances.
  always_comb begin
    state_nxt = state;
    phase_end = (state == S_D0 || state == S_D1) ? (cnt == DIV_LAST) : (cnt == BLANK_LAST);
    cnt_nxt   = phase_end ? '0 : cnt + DIV_W'(1);
    if (phase_end) begin
      unique case (state)
        S_D0:    state_nxt = S_G0;
        S_G0:    state_nxt = S_D1;
        S_D1:    state_nxt = S_G1;
        default: state_nxt = S_D0;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      state <= S_G1;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Snapshot loads only on the G1->D0 edge; the dot flag favours set over clear.
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      snap_u <= '0;
      snap_t <= '0;
      dot    <= 1'b0;
    end else begin
      if (state == S_G1 && phase_end && !FREEZE) begin
        snap_u <= Q0;
        snap_t <= Q1;
      end
      if (OVF)         dot <= 1'b1;
      else if (DP_CLR) dot <= 1'b0;
    end
  end

  assign digit = (state == S_D1) ? snap_t : snap_u;

  seg7_decode u_dec (
    .bcd (digit),
    .seg (dec_seg)
  );

  always_comb begin
    seg_on    = SEG_OFF;
    an_on     = 2'b00;
    dp_on     = 1'b0;
    frame_nxt = (state == S_D0) && (cnt == '0);
    unique case (state)
      S_D0: begin
        seg_on = dec_seg;
        an_on  = 2'b01;
        dp_on  = dot;
      end
      S_D1: begin
        if (!(LZB && snap_t == 4'd0)) begin
          seg_on = dec_seg;
          an_on  = 2'b10;
        end
      end
      default: ;
    endcase
  end

  // Registered pins; polarity applied here so the decode path stays active-high.
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      SEG   <= SEG_INV;
      DP    <= DP_INV;
      AN    <= AN_INV;
      FRAME <= 1'b0;
    end else begin
      SEG   <= seg_on ^ SEG_INV;
      DP    <= dp_on ^ DP_INV;
      AN    <= an_on ^ AN_INV;
      FRAME <= frame_nxt;
    end
  end

endmodule

// File: tb/tb_bcd_seg7_scan.sv
// Bench for bcd_seg7_scan: cycle-indexed reference model, vector table,
// hand-written corner sequences and randomized traffic.
module tb_bcd_seg7_scan;

  localparam int DIV       = 4;
  localparam int BLANK     = 2;
  localparam int FRAME_LEN = 2 * (DIV + BLANK);

  logic       CLK, CLR;
  logic [3:0] Q0, Q1;
  logic       OVF, DP_CLR, LZB, FREEZE;
  logic [6:0] SEG;
  logic       DP;
  logic [1:0] AN;
  logic       FRAME;

  int n_pass, n_chk;
  logic [10:0] exp_q[$];

  int         edge_n;
  logic [3:0] m_u, m_t;
  logic       m_dot;

  typedef struct {
    logic [3:0] t;
    logic [3:0] u;
    logic       lzb;
    logic [6:0] eu;
    logic [6:0] et;
    logic [1:0] ean;
  } vec_t;

  vec_t vecs[6];

  bcd_seg7_scan #(
    .DIV_W(8), .DIV(DIV), .BLANK_CYC(BLANK), .SEG_AL(1), .AN_AL(1)
  ) dut (
    .CLK(CLK), .CLR(CLR), .Q0(Q0), .Q1(Q1), .OVF(OVF), .DP_CLR(DP_CLR),
    .LZB(LZB), .FREEZE(FREEZE), .SEG(SEG), .DP(DP), .AN(AN), .FRAME(FRAME)
  );

  // clock
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  function automatic logic [6:0] ref_dec(input logic [3:0] d);
    case (d)
      4'd0: return 7'h3F;
      4'd1: return 7'h06;
      4'd2: return 7'h5B;
      4'd3: return 7'h4F;
      4'd4: return 7'h66;
      4'd5: return 7'h6D;
      4'd6: return 7'h7D;
      4'd7: return 7'h07;
      4'd8: return 7'h7F;
      4'd9: return 7'h6F;
      default: return 7'h40;
    endcase
  endfunction

  // Expected pins {SEG,DP,AN,FRAME} after edge n counted from reset release.
  function automatic logic [10:0] ref_out(input int n, input logic [3:0] u, input logic [3:0] t,
                                          input logic dot, input logic lzb);
    int q;
    logic [6:0] s;
    logic dp, fr;
    logic [1:0] an;
    s = 7'h00; dp = 1'b0; an = 2'b00; fr = 1'b0;
    if (n >= BLANK + 1) begin
      q  = (n - BLANK - 1) % FRAME_LEN;
      fr = (q == 0);
      if (q < DIV) begin
        s = ref_dec(u); an = 2'b01; dp = dot;
      end else if (q >= DIV + BLANK && q < 2 * DIV + BLANK && !(lzb && t == 4'd0)) begin
        s = ref_dec(t); an = 2'b10;
      end
    end
    return {~s, ~dp, ~an, fr};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_n);
  endtask

  task automatic model_reset();
    edge_n = 0;
    m_u = 4'd0; m_t = 4'd0; m_dot = 1'b0;
    exp_q.delete();
  endtask

  task automatic step();
    @(posedge CLK);
    edge_n++;
    exp_q.push_back(ref_out(edge_n, m_u, m_t, m_dot, LZB));
    if (edge_n >= BLANK && (edge_n - BLANK) % FRAME_LEN == 0 && !FREEZE) begin
      m_u = Q0;
      m_t = Q1;
    end
    if (OVF) m_dot = 1'b1;
    else if (DP_CLR) m_dot = 1'b0;
    @(negedge CLK);
    chk("scan", {SEG, DP, AN, FRAME}, exp_q.pop_front());
  endtask

  task automatic wait_frame();
    int k;
    k = 0;
    do begin
      step();
      k++;
    end while (FRAME !== 1'b1 && k < 2 * FRAME_LEN);
    chk("frame_seen", FRAME, 1'b1);
  endtask

  task automatic do_reset();
    CLR = 1'b0;
    Q0 = 4'd0; Q1 = 4'd0; OVF = 1'b0; DP_CLR = 1'b0; LZB = 1'b0; FREEZE = 1'b0;
    repeat (2) @(negedge CLK);
    chk("rst_seg", SEG, 7'h7F);
    chk("rst_dp", DP, 1'b1);
    chk("rst_an", AN, 2'b11);
    chk("rst_frame", FRAME, 1'b0);
    CLR = 1'b1;
    model_reset();
  endtask

  initial begin
    int first;
    n_pass = 0;
    n_chk  = 0;
    vecs[0] = '{t: 4'd1, u: 4'd7, lzb: 1'b0, eu: 7'h78, et: 7'h79, ean: 2'b01};
    vecs[1] = '{t: 4'd0, u: 4'd5, lzb: 1'b1, eu: 7'h12, et: 7'h7F, ean: 2'b11};
    vecs[2] = '{t: 4'd0, u: 4'd5, lzb: 1'b0, eu: 7'h12, et: 7'h40, ean: 2'b01};
    vecs[3] = '{t: 4'd0, u: 4'hC, lzb: 1'b0, eu: 7'h3F, et: 7'h40, ean: 2'b01};
    vecs[4] = '{t: 4'd9, u: 4'd9, lzb: 1'b1, eu: 7'h10, et: 7'h10, ean: 2'b01};
    vecs[5] = '{t: 4'hF, u: 4'd0, lzb: 1'b1, eu: 7'h40, et: 7'h3F, ean: 2'b01};

    // reset release and first frame position
    do_reset();
    first = 0;
    for (int k = 1; k <= FRAME_LEN; k++) begin
      step();
      if (FRAME === 1'b1 && first == 0) first = k;
    end
    chk("first_frame_cycle", first, BLANK + 1);

    // vector table
    for (int i = 0; i < 6; i++) begin
      Q1 = vecs[i].t; Q0 = vecs[i].u; LZB = vecs[i].lzb;
      step();
      wait_frame();
      chk("units_seg", SEG, vecs[i].eu);
      chk("units_an", AN, 2'b10);
      repeat (DIV + BLANK) step();
      chk("tens_seg", SEG, vecs[i].et);
      chk("tens_an", AN, vecs[i].ean);
    end

    // input change mid-frame is deferred to the next snapshot
    Q1 = 4'd0; Q0 = 4'd3; LZB = 1'b0;
    step();
    wait_frame();
    chk("pre_change_units", SEG, 7'h30);
    repeat (DIV + BLANK) step();
    Q0 = 4'd8;
    repeat (FRAME_LEN - DIV - BLANK - 1) step();
    step();
    chk("post_change_frame", FRAME, 1'b1);
    chk("post_change_units", SEG, 7'h00);

    // freeze holds the snapshot across frames
    Q0 = 4'd3;
    step();
    wait_frame();
    FREEZE = 1'b1;
    Q0 = 4'd8;
    repeat (3 * FRAME_LEN) step();
    wait_frame();
    chk("freeze_units", SEG, 7'h30);
    FREEZE = 1'b0;

    // dot flag: set wins over clear, then clear alone
    OVF = 1'b1; DP_CLR = 1'b1;
    step();
    OVF = 1'b0; DP_CLR = 1'b0;
    wait_frame();
    chk("dp_set_wins", DP, 1'b0);
    step();
    wait_frame();
    chk("dp_sticky", DP, 1'b0);
    DP_CLR = 1'b1;
    step();
    DP_CLR = 1'b0;
    wait_frame();
    chk("dp_cleared", DP, 1'b1);

    // asynchronous clear mid units phase
    step();
    CLR = 1'b0;
    #1;
    chk("async_an", AN, 2'b11);
    chk("async_seg", SEG, 7'h7F);
    chk("async_frame", FRAME, 1'b0);
    @(negedge CLK);
    CLR = 1'b1;
    model_reset();

    // randomized traffic against the model
    repeat (500) begin
      if ($urandom_range(0, 3) == 0) begin
        Q0 = 4'($urandom_range(0, 15));
        Q1 = 4'($urandom_range(0, 15));
      end
      LZB    = ($urandom_range(0, 3) == 0);
      FREEZE = ($urandom_range(0, 9) == 0);
      OVF    = ($urandom_range(0, 19) == 0);
      DP_CLR = ($urandom_range(0, 9) == 0);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
